// File: rtl/tnn_pkg.sv
// Shared types and constants for the TNN classifier front end.
package tnn_pkg;

    // The classifier family is fixed at six 3-bit features.
    localparam int FEAT_W   = 3;
    localparam int NUM_FEAT = 6;

    // Sequencer FSM states; encodings are visible on the debug port.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DRAIN   = 2'd3
    } tnn_state_t;

    // One assembled sample, slot 0 = feature a.
    typedef logic [FEAT_W-1:0] feat_vec_t [NUM_FEAT];

endpackage

// File: rtl/tnn_result_slot.sv
// One-entry valid/ready output register holding the classifier decision,
// plus a counter of decisions accepted downstream.
module tnn_result_slot #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,     // load cap_data this cycle
    input  logic             cap_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic             m_data,
    output logic             slot_free,   // empty, or being emptied this cycle
    output logic [CNT_W-1:0] sample_cnt
);

    logic             m_valid_q, m_valid_d;
    logic             m_data_q,  m_data_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             m_fire;

    // Handshake: a decision transfers on any cycle where m_valid & m_ready.
    // m_valid never looks at m_ready; m_data only moves on a capture, and a
    // capture is only issued when the slot is free, so m_data is stable
    // while the entry is stalled.
    assign m_fire    = m_valid_q & m_ready;
    assign slot_free = ~m_valid_q | m_ready;

    // Next-state: a capture in the same cycle as a pop keeps m_valid high.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;
        if (m_fire) begin
            m_valid_d = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
        end
        if (capture) begin
            m_valid_d = 1'b1;
            m_data_d  = cap_data;
        end
    end

    // Slot registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign sample_cnt = cnt_q;

endmodule

// File: rtl/tnn_feature_sequencer.sv
// Serial-to-parallel feeder for the combinational TNN classifier: assembles
// six feature beats, holds them while the classifier settles, captures the
// 1-bit decision into a valid/ready output slot, and flags malformed samples.
module tnn_feature_sequencer #(
    parameter int NUM_FEAT      = 6,
    parameter int FEAT_W        = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [FEAT_W-1:0]   s_data,
    input  logic                s_last,
    output logic [FEAT_W-1:0]   feat_a,
    output logic [FEAT_W-1:0]   feat_b,
    output logic [FEAT_W-1:0]   feat_c,
    output logic [FEAT_W-1:0]   feat_d,
    output logic [FEAT_W-1:0]   feat_e,
    output logic [FEAT_W-1:0]   feat_f,
    input  logic                cls_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_data,
    output logic                err_short,
    output logic                err_long,
    output logic [CNT_W-1:0]    sample_cnt,
    output tnn_pkg::tnn_state_t dbg_state
);

    import tnn_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(NUM_FEAT - 1);

    tnn_state_t        state_q,     state_d;
    logic [2:0]        idx_q,       idx_d;
    logic [3:0]        settle_q,    settle_d;
    logic [FEAT_W-1:0] feat_q [NUM_FEAT];
    logic [FEAT_W-1:0] feat_n [NUM_FEAT];
    logic              err_short_q, err_short_d;
    logic              err_long_q,  err_long_d;
    logic              s_fire;
    logic              capture;
    logic              slot_free;

    // Input handshake: a beat transfers when s_valid & s_ready. s_ready is a
    // pure decode of the state register, never of s_valid.
    assign s_ready = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    assign s_fire  = s_valid & s_ready;

    // Sequencer next-state: collect beats, wait for settle, capture, or drain.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        feat_n      = feat_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (s_fire) begin
                    if (idx_q == LAST_IDX) begin
                        // Slot f is written even for an over-long sample.
                        feat_n[idx_q] = s_data;
                        idx_d         = 3'd0;
                        if (s_last) begin
                            state_d  = ST_SETTLE;
                            settle_d = 4'(SETTLE_CYCLES);
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        // Early s_last: drop the partial sample, keep feat_*.
                        err_short_d = 1'b1;
                        idx_d       = 3'd0;
                    end else begin
                        feat_n[idx_q] = s_data;
                        idx_d         = idx_q + 3'd1;
                    end
                end
            end
            ST_SETTLE: begin
                settle_d = (settle_q != 4'd0) ? settle_q - 4'd1 : 4'd0;
                // Counter reaches zero on this edge: decision is ready.
                if (settle_q <= 4'd1) begin
                    if (slot_free) begin
                        capture = 1'b1;
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    capture = 1'b1;
                    state_d = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (s_fire && s_last) begin
                    state_d = ST_COLLECT;
                    idx_d   = 3'd0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Sequencer registers; reset drops any sample in progress silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= 3'd0;
            settle_q    <= 4'd0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            for (int i = 0; i < NUM_FEAT; i++) feat_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            for (int i = 0; i < NUM_FEAT; i++) feat_q[i] <= feat_n[i];
        end
    end

    tnn_result_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .cap_data   (cls_in),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .slot_free  (slot_free),
        .sample_cnt (sample_cnt)
    );

    assign feat_a    = feat_q[0];
    assign feat_b    = feat_q[1];
    assign feat_c    = feat_q[2];
    assign feat_d    = feat_q[3];
    assign feat_e    = feat_q[4];
    assign feat_f    = feat_q[5];
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tnn_feature_sequencer.sv
// Bench for tnn_feature_sequencer: directed samples, a parity classifier
// stand-in on the feature outputs, and a decision scoreboard.
module tb_tnn_feature_sequencer;
  import tnn_pkg::*;

  localparam int S  = 2;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s_valid, s_ready, s_last;
  logic [2:0]    s_data;
  logic [2:0]    fa, fb, fc, fd, fe, ff;
  logic          cls_in, m_valid, m_ready, m_data;
  logic          err_short, err_long;
  logic [CW-1:0] sample_cnt;
  tnn_state_t    dbg_state;

  // Classifier stand-in: odd parity of all feature bits.
  assign cls_in = ^{fa, fb, fc, fd, fe, ff};

  tnn_feature_sequencer #(
    .NUM_FEAT(6), .FEAT_W(3), .SETTLE_CYCLES(S), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_a(fa), .feat_b(fb), .feat_c(fc), .feat_d(fd), .feat_e(fe), .feat_f(ff),
    .cls_in(cls_in), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_short(err_short), .err_long(err_long), .sample_cnt(sample_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_dec       = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transferred decision must match the oldest expected one.
  always @(negedge clk) begin : monitor
    logic e;
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_decision: got m_data=%0b expected no decision at %0t", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          miscompares++;
          $display("FAIL decision: got %0b expected %0b at %0t", m_data, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [2:0] d, input logic last, input logic exp_es, input logic exp_el);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout: s_ready=%0b expected 1 within 100 cycles", s_ready);
      s_valid = 1'b0; s_last = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    check("err_short", err_short, exp_es);
    check("err_long", err_long, exp_el);
  endtask

  // Full six-beat sample, feature a in the top bits of vec.
  task automatic send_sample(input logic [17:0] vec);
    for (int i = 0; i < 6; i++)
      send_beat(vec[17-3*i -: 3], (i == 5), 1'b0, 1'b0);
    check("feat_vec", {fa, fb, fc, fd, fe, ff}, vec);
    exp_q.push_back(^vec);
    n_dec++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    logic [17:0] v;
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
    rst_n = 1'b0;
    cycles(1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_state", dbg_state, ST_COLLECT);
    check("rst_feat", {fa, fb, fc, fd, fe, ff}, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_err", {err_short, err_long}, 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(1);

    // 1: nominal capture, latency S+1 after the sixth beat
    send_sample(18'o123456);
    check("lat_early", m_valid, 0);
    for (int k = 1; k < S; k++) begin
      cycles(1);
      check("lat_wait", m_valid, 0);
    end
    cycles(1);
    check("lat_valid", m_valid, 1);
    check("lat_data", m_data, 1);
    m_ready = 1'b1;
    cycles(1);
    check("t1_drained", m_valid, 0);
    check("t1_cnt", sample_cnt, 1);

    // 2: short sample
    send_beat(3'd7, 1'b0, 1'b0, 1'b0);
    send_beat(3'd7, 1'b0, 1'b0, 1'b0);
    send_beat(3'd5, 1'b1, 1'b1, 1'b0);
    cycles(1);
    check("short_pulse_end", err_short, 0);
    cycles(S + 2);
    check("short_no_valid", m_valid, 0);
    check("short_state", dbg_state, ST_COLLECT);
    send_sample(18'o765432);
    cycles(S + 3);
    check("t2_cnt", sample_cnt, 32'(n_dec % 16));

    // 3: long sample, 8 beats with s_last on the 8th
    for (int i = 0; i < 6; i++)
      send_beat(3'(i + 2), 1'b0, 1'b0, (i == 5));
    check("long_state", dbg_state, ST_DRAIN);
    send_beat(3'd1, 1'b0, 1'b0, 1'b0);
    send_beat(3'd2, 1'b1, 1'b0, 1'b0);
    check("long_back", dbg_state, ST_COLLECT);
    cycles(S + 3);
    check("long_no_valid", m_valid, 0);

    // 4: backpressure, two decisions queued behind m_ready=0
    m_ready = 1'b0;
    send_sample(18'o000000);
    cycles(S + 1);
    check("bp_first_valid", m_valid, 1);
    check("bp_first_data", m_data, 0);
    send_sample(18'o123456);
    cycles(S + 2);
    check("bp_hold_state", dbg_state, ST_HOLD);
    check("bp_hold_ready", s_ready, 0);
    check("bp_held_data", m_data, 0);
    m_ready = 1'b1;
    cycles(1);
    m_ready = 1'b0;
    check("bp_nobubble_valid", m_valid, 1);
    check("bp_second_data", m_data, 1);
    check("bp_state_back", dbg_state, ST_COLLECT);
    cycles(1);
    check("bp_stall_valid", m_valid, 1);
    m_ready = 1'b1;
    cycles(1);
    check("bp_drained", m_valid, 0);
    check("bp_cnt", sample_cnt, 32'(n_dec % 16));

    // 5: counter wrap, 13 more decisions bring the total to 17
    for (int k = 0; k < 13; k++) begin
      for (int j = 0; j < 6; j++) v[17-3*j -: 3] = 3'((k * 3 + j) % 8);
      send_sample(v);
    end
    cycles(S + 3);
    check("wrap_cnt", sample_cnt, 1);

    // 6: asynchronous reset in the middle of a sample
    send_beat(3'd2, 1'b0, 1'b0, 1'b0);
    send_beat(3'd3, 1'b0, 1'b0, 1'b0);
    send_beat(3'd4, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_feat", {fa, fb, fc, fd, fe, ff}, 0);
    check("arst_cnt", sample_cnt, 0);
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_err", {err_short, err_long}, 0);
    check("arst_state", dbg_state, ST_COLLECT);
    check("arst_s_ready", s_ready, 1);
    n_dec = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_sample(18'o123456);
    cycles(S + 3);
    check("arst_after_cnt", sample_cnt, 32'(n_dec % 16));

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a wedged handshake.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
